// File: rtl/booth_arb_pkg.sv
// Shared types and sizing helpers for the Booth multiplier arbiter.
package booth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b11,
        RESP  = 2'b10
    } arb_state_t;

    localparam int unsigned DEF_DATAWIDTH = 32;
    localparam int unsigned DEF_NREQ      = 4;
    localparam int unsigned DEF_PTR_W     = $clog2(DEF_NREQ);

    // Pointer width for a given requester count, never below one bit.
    function automatic int unsigned ptr_width(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Default watchdog limit: nominal Booth latency plus a small margin.
    function automatic int unsigned default_timeout(input int unsigned dw);
        return 2 * dw + 8;
    endfunction

endpackage

// File: rtl/booth_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
module booth_rr_picker
    import booth_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned PTR_W = DEF_PTR_W
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  grant,
    output logic             found
);

    logic [PTR_W-1:0] idx;

    // Scan requesters starting at rr_ptr; the first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PTR_W'((32'(rr_ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle Booth multiplier.
// Optional watchdog: define BOOTH_ARB_WATCHDOG_EN to abort a stuck multiply.
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
    parameter int unsigned NREQ      = DEF_NREQ,
    parameter int unsigned TIMEOUT   = default_timeout(DATAWIDTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DATAWIDTH-1:0] req_multiplier,
    input  logic [NREQ*DATAWIDTH-1:0] req_multiplicand,
    output logic [NREQ-1:0]           resp_valid,
    input  logic [NREQ-1:0]           resp_ready,
    output logic [2*DATAWIDTH-1:0]    resp_product,
    output logic                      resp_err,
    output logic                      busy,
    output logic                      mul_en,
    output logic [DATAWIDTH-1:0]      mul_multiplier,
    output logic [DATAWIDTH-1:0]      mul_multiplicand,
    input  logic                      mul_done,
    input  logic [2*DATAWIDTH-1:0]    mul_product
);

    localparam int unsigned PTR_W = ptr_width(NREQ);

    arb_state_t       state;
    arb_state_t       state_nx;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_r;
    logic [PTR_W-1:0] grant_idx;
    logic [NREQ-1:0]  pick_onehot;
    logic             pick_found;
    logic             grant_c;
    logic             done_c;
    logic             timeout_c;

    logic [DATAWIDTH-1:0] mplr_arr [NREQ];
    logic [DATAWIDTH-1:0] mcnd_arr [NREQ];

    // Split the flat operand buses into per-requester slices.
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign mplr_arr[g] = req_multiplier[g*DATAWIDTH +: DATAWIDTH];
        assign mcnd_arr[g] = req_multiplicand[g*DATAWIDTH +: DATAWIDTH];
    end

    booth_rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_onehot),
        .found  (pick_found)
    );

    // One-hot grant to index for the operand mux and grant register.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

`ifdef BOOTH_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;

    // Last WAIT cycle allowed before the multiply is abandoned.
    assign timeout_c = (state == WAIT) && !mul_done && (wd_cnt == WD_W'(TIMEOUT - 1));

    // Watchdog counter and abort flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt   <= '0;
            resp_err <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (done_c) begin
                resp_err <= 1'b0;
            end else if (timeout_c) begin
                resp_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_c = 1'b0;
    assign resp_err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and per-cycle event strobes.
    always_comb begin
        state_nx = state;
        grant_c  = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_c  = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    done_c   = 1'b1;
                    state_nx = RESP;
                end else if (timeout_c) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (resp_ready[grant_r]) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Grant bookkeeping, operand capture and result capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr           <= '0;
            grant_r          <= '0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            resp_product     <= '0;
        end else begin
            if (grant_c) begin
                rr_ptr           <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                grant_r          <= grant_idx;
                mul_multiplier   <= mplr_arr[grant_idx];
                mul_multiplicand <= mcnd_arr[grant_idx];
            end
            if (done_c) begin
                resp_product <= mul_product;
            end else if (timeout_c) begin
                resp_product <= '0;
            end
        end
    end

    // Handshake outputs decoded from the registered state.
    assign req_ready  = (state == IDLE) ? pick_onehot : '0;
    assign resp_valid = (state == RESP) ? (NREQ'(1) << grant_r) : '0;
    assign busy       = (state != IDLE);
    assign mul_en     = (state == ISSUE);

endmodule
